// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and framebuffer coordinate types for the
// scanout, the line drawer and the framebuffer.
package vga_pkg;
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int H_TOTAL      = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL      = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  localparam int CNT_W = 10;

  typedef logic [9:0]       coord_x_t;
  typedef logic [8:0]       coord_y_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/vga_sync_gen.sv
// Pixel phase, h/v raster counters and the sync/visible/frame-wrap decode.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic     clk,
  input  logic     reset_n,
  output logic     ph,
  output coord_x_t x,
  output coord_y_t y,
  output logic     visible,
  output logic     hsync_n,
  output logic     vsync_n,
  output logic     frame_wrap
);
  localparam int   LINE_LEN    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int   FRAME_LINES = V_VIS + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_LAST   = cnt_t'(LINE_LEN - 1);
  localparam cnt_t V_LAST   = cnt_t'(FRAME_LINES - 1);
  localparam cnt_t H_VIS_C  = cnt_t'(H_VIS);
  localparam cnt_t V_VIS_C  = cnt_t'(V_VIS);
  localparam cnt_t HS_START = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
  localparam cnt_t VS_START = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_VIS + V_FP + V_SYNC - 1);

  cnt_t h_cnt, v_cnt;

  // Counters step only on the edge that closes phase 1 of a pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph    <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      ph <= ~ph;
      if (ph) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign x          = coord_x_t'(h_cnt);
  assign y          = v_cnt[8:0];
  assign visible    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hsync_n    = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
  assign vsync_n    = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
  assign frame_wrap = ph && (h_cnt == H_LAST) && (v_cnt == V_LAST);
endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: drives the read port from the raster position and
// registers colour/blank/sync onto the VGA DAC pins once per pixel period.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int          H_VIS    = DEF_H_VIS,
  parameter int          H_FP     = DEF_H_FP,
  parameter int          H_SYNC   = DEF_H_SYNC,
  parameter int          H_BP     = DEF_H_BP,
  parameter int          V_VIS    = DEF_V_VIS,
  parameter int          V_FP     = DEF_V_FP,
  parameter int          V_SYNC   = DEF_V_SYNC,
  parameter int          V_BP     = DEF_V_BP,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       rd_en,
  output logic [9:0] rd_x,
  output logic [8:0] rd_y,
  input  logic       rd_data,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_n,
  output logic       VGA_SYNC_n,
  output logic       frame_start
);
  logic     ph, visible, hsync_n, vsync_n, frame_wrap;
  coord_x_t x;
  coord_y_t y;

  vga_sync_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_sync (
    .clk(clk), .reset_n(reset_n), .ph(ph), .x(x), .y(y), .visible(visible),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .frame_wrap(frame_wrap)
  );

  // Gated by reset_n so the strobe is quiet while held in reset even though
  // the counters already sit on a visible pixel.
  assign rd_en      = reset_n && !ph && visible;
  assign rd_x       = x;
  assign rd_y       = y;
  assign VGA_CLK    = ph;
  assign VGA_SYNC_n = 1'b0;

  // Load at the end of phase 1, i.e. on the VGA_CLK falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {VGA_R, VGA_G, VGA_B} <= 24'h0;
      VGA_BLANK_n <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (ph) begin
        {VGA_R, VGA_G, VGA_B} <= visible ? (rd_data ? FG_COLOR : BG_COLOR) : 24'h0;
        VGA_BLANK_n <= visible;
        VGA_HS      <= hsync_n;
        VGA_VS      <= vsync_n;
      end
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// Bench: full-size instance for line timing, shrunk-raster instance for
// frame-level behaviour, mid-frame reset and background colour.
module tb_vga_scanout;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_a, rst_b;
  logic       en_a, en_b, rdat_a, rdat_b;
  logic [9:0] x_a, x_b;
  logic [8:0] y_a, y_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       vclk_a, hs_a, vs_a, bl_a, sn_a, fs_a;
  logic       vclk_b, hs_b, vs_b, bl_b, sn_b, fs_b;
  logic [23:0] rgb_a, rgb_b;
  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};

  vga_scanout dut_a (
    .clk(clk), .reset_n(rst_a), .rd_en(en_a), .rd_x(x_a), .rd_y(y_a),
    .rd_data(rdat_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_CLK(vclk_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_n(bl_a), .VGA_SYNC_n(sn_a),
    .frame_start(fs_a)
  );

  // 15x8 raster (line 30 clk, frame 240 clk), hsync h=10..12, vsync v=5..6
  vga_scanout #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FG_COLOR(24'hFF0000), .BG_COLOR(24'h0000FF)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .rd_en(en_b), .rd_x(x_b), .rd_y(y_b),
    .rd_data(rdat_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_CLK(vclk_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_n(bl_b), .VGA_SYNC_n(sn_b),
    .frame_start(fs_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_reset(input string tag, input logic en, input logic [23:0] rgb,
                           input logic bl, input logic hs, input logic vs,
                           input logic vclk, input logic fs, input logic sn);
    chk({tag, "_rd_en"}, int'(en), 0);
    chk({tag, "_rgb"}, int'(rgb), 0);
    chk({tag, "_blank_n"}, int'(bl), 0);
    chk({tag, "_hs"}, int'(hs), 1);
    chk({tag, "_vs"}, int'(vs), 1);
    chk({tag, "_vga_clk"}, int'(vclk), 0);
    chk({tag, "_frame_start"}, int'(fs), 0);
    chk({tag, "_sync_n"}, int'(sn), 0);
  endtask

  // Cycle s counts clk periods from reset release: s = 2*h + ph + 1600*v.
  typedef struct {
    int cyc; int en; int x; int y; int hs; int bl; int vclk; int rgb;
  } vec_t;
  vec_t va[$];

  initial begin
    int pen, px, py, idx, exp_x, n_en, bad_x, hs_low, hs_first, bad_misc;
    int n_bl, vs_low, vs_first, fg_n, fg_first, bg_n, bad_col, fs_n, fs_last;
    int fs2_n, fs2_first;
    logic frc;

    //           cyc  en  x    y  hs bl vclk rgb
    va.push_back('{0,    1, 0,   0, 1, 0, 0, 0});
    va.push_back('{1,    0, 0,   0, 1, 0, 1, 0});
    va.push_back('{2,    1, 1,   0, 1, 1, 0, 0});
    va.push_back('{10,   1, 5,   0, 1, 1, 0, 0});
    va.push_back('{11,   0, 5,   0, 1, 1, 1, 0});
    va.push_back('{12,   1, 6,   0, 1, 1, 0, 32'hFFFFFF});
    va.push_back('{13,   0, 6,   0, 1, 1, 1, 32'hFFFFFF});
    va.push_back('{14,   1, 7,   0, 1, 1, 0, 0});
    va.push_back('{1279, 0, 639, 0, 1, 1, 1, 0});
    va.push_back('{1280, 0, 640, 0, 1, 1, 0, 0});
    va.push_back('{1282, 0, 641, 0, 1, 0, 0, 0});
    va.push_back('{1313, 0, 656, 0, 1, 0, 1, 0});
    va.push_back('{1314, 0, 657, 0, 0, 0, 0, 0});
    va.push_back('{1402, 0, 701, 0, 0, 0, 0, 0});
    va.push_back('{1403, 0, 701, 0, 0, 0, 1, 0});
    va.push_back('{1505, 0, 752, 0, 0, 0, 1, 0});
    va.push_back('{1506, 0, 753, 0, 1, 0, 0, 0});
    va.push_back('{1600, 1, 0,   1, 1, 0, 0, 0});
    va.push_back('{1602, 1, 1,   1, 1, 1, 0, 0});

    rst_a = 1'b0; rst_b = 1'b0; rdat_a = 1'b0; rdat_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("a_rst", en_a, rgb_a, bl_a, hs_a, vs_a, vclk_a, fs_a, sn_a);
    chk_reset("b_rst", en_b, rgb_b, bl_b, hs_b, vs_b, vclk_b, fs_b, sn_b);

    // ---- full-size raster: first line and start of the second ----
    @(negedge clk); rst_a = 1'b1; #1;
    pen = 0; px = 0; py = 0; idx = 0; exp_x = 0; n_en = 0; bad_x = 0;
    hs_low = 0; hs_first = -1; bad_misc = 0;
    for (int s = 0; s <= 1610; s++) begin
      // memory holds a single set pixel at (5,0); rd_data forced high around h=700
      frc = (s >= 1380 && s <= 1421);
      rdat_a = (pen == 1 && px == 5 && py == 0) || frc;
      if (s < 1600) begin
        if (en_a) begin
          n_en++;
          if (int'(x_a) != exp_x || int'(y_a) != 0) bad_x++;
          exp_x++;
        end
        if (!hs_a) begin
          if (hs_low == 0) hs_first = s;
          hs_low++;
        end
      end
      if (fs_a || !vs_a || sn_a) bad_misc++;
      if (idx < va.size() && va[idx].cyc == s) begin
        chk($sformatf("a_c%0d_rd_en", s), int'(en_a), va[idx].en);
        chk($sformatf("a_c%0d_rd_x", s), int'(x_a), va[idx].x);
        chk($sformatf("a_c%0d_rd_y", s), int'(y_a), va[idx].y);
        chk($sformatf("a_c%0d_hs", s), int'(hs_a), va[idx].hs);
        chk($sformatf("a_c%0d_blank_n", s), int'(bl_a), va[idx].bl);
        chk($sformatf("a_c%0d_vga_clk", s), int'(vclk_a), va[idx].vclk);
        chk($sformatf("a_c%0d_rgb", s), int'(rgb_a), va[idx].rgb);
        idx++;
      end
      pen = int'(en_a); px = int'(x_a); py = int'(y_a);
      @(negedge clk); #1;
    end
    chk("a_vectors_applied", idx, va.size());
    chk("a_rd_en_per_line", n_en, 640);
    chk("a_rd_x_sequence_errors", bad_x, 0);
    chk("a_hs_first_low_clk", hs_first, 1314);
    chk("a_hs_low_clks", hs_low, 192);
    chk("a_fs_vs_sync_errors", bad_misc, 0);
    rst_a = 1'b0;

    // ---- shrunk raster: frame stats, set pixel at (3,2), BG colour ----
    @(negedge clk); rst_b = 1'b1; #1;
    pen = 0; px = 0; py = 0;
    n_bl = 0; vs_low = 0; vs_first = -1; fg_n = 0; fg_first = -1; bg_n = 0;
    bad_col = 0; fs_n = 0; fs_last = -1;
    for (int t = 0; t <= 308; t++) begin
      rdat_b = (pen == 1 && px == 3 && py == 2);
      if (t < 240) begin
        if (bl_b) n_bl++;
        if (!vs_b) begin
          if (vs_low == 0) vs_first = t;
          vs_low++;
        end
        if (rgb_b == 24'hFF0000) begin
          if (fg_n == 0) fg_first = t;
          fg_n++;
        end else if (bl_b && rgb_b == 24'h0000FF) bg_n++;
        else if (!(!bl_b && rgb_b == 24'h0)) bad_col++;
      end
      if (fs_b) begin
        fs_n++;
        fs_last = t;
      end
      if (t == 66) begin
        chk("b_strobe_rd_en", int'(en_b), 1);
        chk("b_strobe_rd_x", int'(x_b), 3);
        chk("b_strobe_rd_y", int'(y_b), 2);
      end
      pen = int'(en_b); px = int'(x_b); py = int'(y_b);
      if (t < 308) begin
        @(negedge clk); #1;
      end
    end
    chk("b_blank_high_clks", n_bl, 64);
    chk("b_vs_first_low_clk", vs_first, 152);
    chk("b_vs_low_clks", vs_low, 60);
    chk("b_fg_first_clk", fg_first, 68);
    chk("b_fg_clks", fg_n, 2);
    chk("b_bg_clks", bg_n, 62);
    chk("b_colour_errors", bad_col, 0);
    chk("b_frame_start_count", fs_n, 1);
    chk("b_frame_start_clk", fs_last, 240);

    // mid-frame reset at (4,2) of the second frame
    chk("b_midframe_rd_x", int'(x_b), 4);
    chk("b_midframe_rd_y", int'(y_b), 2);
    rst_b = 1'b0; #1;
    chk_reset("b_midrst", en_b, rgb_b, bl_b, hs_b, vs_b, vclk_b, fs_b, sn_b);
    repeat (2) @(negedge clk);
    @(negedge clk); rst_b = 1'b1; #1;
    pen = 0; px = 0; py = 0; fs2_n = 0; fs2_first = -1;
    for (int t = 0; t <= 242; t++) begin
      rdat_b = (pen == 1 && px == 3 && py == 2);
      if (t == 0) begin
        chk("b_restart_rd_en", int'(en_b), 1);
        chk("b_restart_rd_x", int'(x_b), 0);
        chk("b_restart_rd_y", int'(y_b), 0);
      end
      if (t == 2) begin
        chk("b_restart_blank_n", int'(bl_b), 1);
        chk("b_restart_bg_rgb", int'(rgb_b), 32'h0000FF);
      end
      if (fs_b) begin
        if (fs2_n == 0) fs2_first = t;
        fs2_n++;
      end
      pen = int'(en_b); px = int'(x_b); py = int'(y_b);
      @(negedge clk); #1;
    end
    chk("b_restart_frame_start_count", fs2_n, 1);
    chk("b_restart_frame_start_clk", fs2_first, 240);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
